// File: rtl/dm_pkg.sv
// Shared constants, FSM encoding and request check for the block copier.
package dm_pkg;

    localparam int DM_ADDR_W = 12;
    localparam int DM_DATA_W = 32;
    localparam int MEM_WORDS = 1 << DM_ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_READ,
        S_WAIT,
        S_WRITE,
        S_FIN
    } state_t;

    typedef struct packed {
        logic bad;
        logic zero;
        logic desc;
    } chk_t;

    function automatic chk_t check_req(
        input logic [DM_ADDR_W-1:0] src,
        input logic [DM_ADDR_W-1:0] dst,
        input logic [DM_ADDR_W-1:0] len
    );
        chk_t r;
        logic [DM_ADDR_W:0] se;
        logic [DM_ADDR_W:0] de;
        se     = {1'b0, src} + {1'b0, len};
        de     = {1'b0, dst} + {1'b0, len};
        r.bad  = (se > (DM_ADDR_W+1)'(MEM_WORDS)) ||
                 (de > (DM_ADDR_W+1)'(MEM_WORDS));
        r.zero = (len == '0);
        // dst inside (src, src+len) would clobber unread source words
        r.desc = (dst > src) && ({1'b0, dst} < se);
        return r;
    endfunction

endpackage

// File: rtl/dm_block_copy.sv
// Block copy engine on the data-memory port; physical addressing,
// memmove semantics for overlapping regions.
module dm_block_copy
    import dm_pkg::*;
#(
    parameter int ADDR_W   = DM_ADDR_W,
    parameter int DATA_W   = DM_DATA_W,
    parameter int READ_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [ADDR_W-1:0] length,
    input  logic [DATA_W-1:0] mem_read,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_we,
    output logic              mem_flagSO,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_t            state, state_n;
    logic [ADDR_W-1:0] src_q, src_n;
    logic [ADDR_W-1:0] dst_q, dst_n;
    logic [ADDR_W-1:0] len_q, len_n;
    chk_t              chk_q, chk_n;
    chk_t              req;
    logic [ADDR_W-1:0] idx, idx_n;
    logic [ADDR_W-1:0] cnt, cnt_n;
    logic [1:0]        wcnt, wcnt_n;
    logic [ADDR_W-1:0] addr_n;
    logic [DATA_W-1:0] data_n;
    logic              we_n, busy_n, done_n, err_n;

    assign mem_flagSO = 1'b0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            src_q       <= '0;
            dst_q       <= '0;
            len_q       <= '0;
            chk_q       <= '0;
            idx         <= '0;
            cnt         <= '0;
            wcnt        <= '0;
            mem_address <= '0;
            mem_data    <= '0;
            mem_we      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= state_n;
            src_q       <= src_n;
            dst_q       <= dst_n;
            len_q       <= len_n;
            chk_q       <= chk_n;
            idx         <= idx_n;
            cnt         <= cnt_n;
            wcnt        <= wcnt_n;
            mem_address <= addr_n;
            mem_data    <= data_n;
            mem_we      <= we_n;
            busy        <= busy_n;
            done        <= done_n;
            err         <= err_n;
        end
    end

    // Outputs are registered from next-state values so each one is
    // valid during the state it belongs to.
    always_comb begin
        state_n = state;
        src_n   = src_q;
        dst_n   = dst_q;
        len_n   = len_q;
        chk_n   = chk_q;
        idx_n   = idx;
        cnt_n   = cnt;
        wcnt_n  = wcnt;
        addr_n  = mem_address;
        data_n  = mem_data;
        we_n    = 1'b0;
        busy_n  = busy;
        done_n  = 1'b0;
        err_n   = 1'b0;
        req     = check_req(src_base, dst_base, length);
        unique case (state)
            S_IDLE: begin
                busy_n = 1'b0;
                if (start) begin
                    src_n   = src_base;
                    dst_n   = dst_base;
                    len_n   = length;
                    chk_n   = req;
                    busy_n  = 1'b1;
                    err_n   = req.bad;
                    state_n = S_CHECK;
                end
            end
            S_CHECK: begin
                if (chk_q.bad) begin
                    busy_n  = 1'b0;
                    state_n = S_IDLE;
                end else if (chk_q.zero) begin
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    state_n = S_FIN;
                end else begin
                    idx_n   = chk_q.desc ? len_q - 1'b1 : '0;
                    cnt_n   = len_q;
                    addr_n  = src_q + idx_n;
                    state_n = S_READ;
                end
            end
            S_READ: begin
                wcnt_n  = '0;
                state_n = S_WAIT;
            end
            S_WAIT: begin
                if (wcnt == 2'(READ_LAT - 1)) begin
                    data_n  = mem_read;
                    addr_n  = dst_q + idx;
                    we_n    = 1'b1;
                    state_n = S_WRITE;
                end else begin
                    wcnt_n = wcnt + 2'd1;
                end
            end
            S_WRITE: begin
                cnt_n = cnt - 1'b1;
                if (cnt == ADDR_W'(1)) begin
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    state_n = S_FIN;
                end else begin
                    idx_n   = chk_q.desc ? idx - 1'b1 : idx + 1'b1;
                    addr_n  = src_q + idx_n;
                    state_n = S_READ;
                end
            end
            S_FIN: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule
